// File: rtl/sync_fifo_lvl.sv
// Synchronous register-array FIFO with fill level, almost-full/empty thresholds,
// sticky overflow/underflow flags and a read-valid strobe. Define FIFO_FLUSH_EN to add flush_i.
module sync_fifo_lvl #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              re_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    output logic [AWIDTH:0]   fill_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o,
    input  logic              clr_err_i
`ifdef FIFO_FLUSH_EN
    ,
    input  logic              flush_i
`endif
);

    localparam int DEPTH = 1 << AWIDTH;

    localparam logic [AWIDTH:0]   FILL_FULL = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_CNT    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0]   AE_CNT    = (AWIDTH+1)'(AE_LEVEL);
    localparam logic [AWIDTH:0]   FILL_ONE  = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE   = AWIDTH'(1);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_level_range
        $error("sync_fifo_lvl: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_level_range
        $error("sync_fifo_lvl: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH:0]   fill_q;

    logic we_req;
    logic re_req;
    logic rd_acc;
    logic wr_acc;

    // A flush swallows the cycle's requests, so they neither move data nor raise errors.
`ifdef FIFO_FLUSH_EN
    assign we_req = we_i & ~flush_i;
    assign re_req = re_i & ~flush_i;
`else
    assign we_req = we_i;
    assign re_req = re_i;
`endif

    assign rd_acc = re_req & ~empty_o;
    assign wr_acc = we_req & (~full_o | rd_acc);

    assign fill_o         = fill_q;
    assign empty_o        = (fill_q == '0);
    assign full_o         = (fill_q == FILL_FULL);
    assign almost_full_o  = (fill_q >= AF_CNT);
    assign almost_empty_o = (fill_q <= AE_CNT);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill_q      <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            // A new error event outranks a simultaneous clear.
            overflow_o  <= (overflow_o  & ~clr_err_i) | (we_req & ~wr_acc);
            underflow_o <= (underflow_o & ~clr_err_i) | (re_req & ~rd_acc);
`ifdef FIFO_FLUSH_EN
            if (flush_i) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                fill_q  <= '0;
                valid_o <= 1'b0;
            end else
`endif
            begin
                valid_o <= rd_acc;
                if (rd_acc) begin
                    data_o <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                case ({wr_acc, rd_acc})
                    2'b10:   fill_q <= fill_q + FILL_ONE;
                    2'b01:   fill_q <= fill_q - FILL_ONE;
                    default: fill_q <= fill_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Randomised and directed bench for sync_fifo_lvl: a queue-based reference model feeds a
// read-data scoreboard that a negedge monitor drains whenever valid_o is seen.
module tb_sync_fifo_lvl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0;
    logic [DW-1:0] din = '0;
    logic          re = 1'b0;
    logic          clr = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [AW:0]   fill_o;
    logic          empty_o, full_o, almost_full_o, almost_empty_o;
    logic          overflow_o, underflow_o;

    int checks = 0;
    int errors = 0;

    int mq[$];
    int exp_q[$];
    bit m_valid = 1'b0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int m_last = 0;

    sync_fifo_lvl #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk),
        .reset(reset),
        .we_i(we),
        .data_i(din),
        .re_i(re),
        .data_o(data_o),
        .valid_o(valid_o),
        .fill_o(fill_o),
        .empty_o(empty_o),
        .full_o(full_o),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o),
        .overflow_o(overflow_o),
        .underflow_o(underflow_o),
        .clr_err_i(clr)
`ifdef FIFO_FLUSH_EN
        ,
        .flush_i(flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a plain queue, updated at every rising edge.
    always @(posedge clk or posedge reset) begin
        bit rd_ok, wr_ok;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            rd_ok = re && (mq.size() > 0);
            wr_ok = we && (mq.size() < DEPTH || rd_ok);
            if (rd_ok) exp_q.push_back(mq.pop_front());
            if (wr_ok) mq.push_back(int'(din));
            m_valid = rd_ok;
            m_ovf = (m_ovf && !clr) || (we && !wr_ok);
            m_unf = (m_unf && !clr) || (re && !rd_ok);
        end
    end

    // Monitor: compares DUT outputs against the model between edges.
    always @(negedge clk) begin
        int e;
        if (reset) begin
            m_last = 0;
        end else begin
            chk("valid", int'(valid_o), int'(m_valid));
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data got %0h expected no read at %0t", data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", int'(data_o), e);
                    m_last = e;
                end
            end else begin
                chk("data_hold", int'(data_o), m_last);
            end
            chk("fill", int'(fill_o), mq.size());
            chk("empty", int'(empty_o), int'(mq.size() == 0));
            chk("full", int'(full_o), int'(mq.size() == DEPTH));
            chk("almost_full", int'(almost_full_o), int'(mq.size() >= AF));
            chk("almost_empty", int'(almost_empty_o), int'(mq.size() <= AE));
            chk("overflow", int'(overflow_o), int'(m_ovf));
            chk("underflow", int'(underflow_o), int'(m_unf));
        end
    end

    task automatic step(input bit w, input int d, input bit r, input bit c, input bit f);
        we = w;
        din = DW'(d);
        re = r;
        clr = c;
        flush = f;
        @(negedge clk);
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_fill", int'(fill_o), 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_ae", int'(almost_empty_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_af", int'(almost_full_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_unf", int'(underflow_o), 0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);

        for (int i = 1; i <= 16; i++) begin
            step(1, (i == 16) ? 8'h10 : 8'h10 + i, 0, 0, 0);
            if (i == 13) chk("af_before_14", int'(almost_full_o), 0);
            if (i == 14) chk("af_at_14", int'(almost_full_o), 1);
        end
        chk("fill16", int'(fill_o), 16);
        chk("full16", int'(full_o), 1);
        chk("ovf_none", int'(overflow_o), 0);

        step(1, 8'hAA, 0, 0, 0);
        chk("drop_ovf", int'(overflow_o), 1);
        chk("drop_fill", int'(fill_o), 16);
        step(0, 0, 0, 1, 0);
        chk("clr_ovf", int'(overflow_o), 0);

        step(1, 8'h55, 1, 0, 0);
        chk("rw_full_fill", int'(fill_o), 16);
        chk("rw_full_data", int'(data_o), 8'h11);
        chk("rw_full_valid", int'(valid_o), 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        chk("drain_last", int'(data_o), 8'h55);
        chk("drain_empty", int'(empty_o), 1);
        step(0, 0, 0, 0, 0);

        step(1, 8'h3C, 1, 0, 0);
        chk("wt_fill", int'(fill_o), 1);
        chk("wt_valid", int'(valid_o), 0);
        chk("wt_unf", int'(underflow_o), 1);
        step(0, 0, 1, 0, 0);
        chk("wt_data", int'(data_o), 8'h3C);
        chk("wt_valid2", int'(valid_o), 1);
        chk("wt_empty", int'(empty_o), 1);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, 8'h80 + i, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 8'h40 + i, 1, 0, 0);
            chk("stream_fill", int'(fill_o), 3);
            chk("stream_err", int'({overflow_o, underflow_o}), 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

`ifdef FIFO_FLUSH_EN
        for (int i = 0; i < 5; i++) step(1, 8'hC0 + i, 0, 0, 0);
        chk("pre_flush_fill", int'(fill_o), 5);
        step(1, 8'hEE, 0, 0, 1);
        chk("flush_fill", int'(fill_o), 0);
        chk("flush_empty", int'(empty_o), 1);
        chk("flush_ovf", int'(overflow_o), 0);
        step(0, 0, 1, 0, 0);
        chk("post_flush_valid", int'(valid_o), 0);
        chk("post_flush_unf", int'(underflow_o), 1);
        step(0, 0, 0, 1, 0);
`endif

        for (int i = 0; i < 1500; i++) begin
            int wp;
            bit f;
            wp = ((i / 150) % 2 == 0) ? 75 : 30;
            f = 1'b0;
`ifdef FIFO_FLUSH_EN
            f = ($urandom_range(0, 59) == 0);
`endif
            if (i == 700) begin
                reset = 1'b1;
                step(0, 0, 0, 0, 0);
                reset = 1'b0;
            end
            step($urandom_range(0, 99) < wp, $urandom_range(0, 255),
                 $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 19) == 0, f);
        end

        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_empty", int'(empty_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
